trig_watchdog: RTL and testbench

- Parametrised, multi-channel stuck-trigger watchdog for the fir_trig datapath.
- Watches the per-channel ToT bits for a trigger that stays asserted too long.
- When it finds one, it drives the baseline-sum recovery inputs: pause_override_in, bsum_reset, or both.
- Mode and timing are runtime-programmable. Sticky diagnostics are kept for slow-control readout.

---
 rtl/trig_watchdog.sv | 205 ++++++++++++++++++++
 tb/tb_trig_watchdog.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/trig_watchdog.sv
// -----------------------------------------------------------------------------
// trig_watchdog
// Multi-channel stuck-trigger watchdog for the fir_trig datapath. It counts
// consecutive cycles in which any ToT channel is high. When that run reaches
// trig_limit, it starts a recovery action on the baseline-sum logic: a held
// pause_override, a one-cycle bsum_reset, or both. After the action, a holdoff
// window follows, then the watchdog re-arms. Sticky diagnostics (channel mask
// and a saturating event count) are kept for slow-control readout.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   tot            per-channel time-over-threshold bits (bit i = channel i)
//   enable         watchdog enable; low forces IDLE on the next edge
//   mode           0 = PAUSE, 1 = RESET, 2 = BOTH, 3 = PAUSE
//   trig_limit     consecutive any-trig cycles before firing (0 disables)
//   override_len   pause_override hold length in cycles (0 behaves as 1)
//   holdoff_len    cycles ignored after an action
//   clear          clears the sticky diagnostics
//   pause_override to fir_trig pause_override_in
//   bsum_reset     to fir_trig bsum_reset, one-cycle pulse
//   busy           high while in OVERRIDE or HOLDOFF
//   stuck_mask     sticky OR of tot at each firing edge
//   stuck_count    saturating number of firings
// -----------------------------------------------------------------------------
module trig_watchdog #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int EVT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] tot,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  trig_limit,
    input  logic [CNT_W-1:0]  override_len,
    input  logic [CNT_W-1:0]  holdoff_len,
    input  logic              clear,
    output logic              pause_override,
    output logic              bsum_reset,
    output logic              busy,
    output logic [NUM_CH-1:0] stuck_mask,
    output logic [EVT_W-1:0]  stuck_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OVERRIDE = 2'd1,
        ST_HOLDOFF  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [EVT_W-1:0]  EVT_ONE  = EVT_W'(1);
    localparam logic [EVT_W-1:0]  EVT_MAX  = {EVT_W{1'b1}};
    localparam logic [NUM_CH-1:0] MASK_ZERO = {NUM_CH{1'b0}};

    // Saturating increment for the run-length counter
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Saturating increment for the event counter
    function automatic logic [EVT_W-1:0] sat_inc_evt(input logic [EVT_W-1:0] v);
        return (v == EVT_MAX) ? v : v + EVT_ONE;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  trig_len_r;
    logic [CNT_W-1:0]  cnt_r;        // down-counter shared by OVERRIDE and HOLDOFF
    logic [CNT_W-1:0]  hold_len_r;   // holdoff length captured at the firing edge
    logic              pause_r;
    logic              bsum_r;
    logic              busy_r;
    logic [NUM_CH-1:0] mask_r;
    logic [EVT_W-1:0]  count_r;

    logic              any_trig_s;
    logic              fire_s;
    logic              pause_mode_s;
    logic              reset_mode_s;
    logic [CNT_W-1:0]  ovl_load_s;

    assign any_trig_s   = |tot;
    // trig_limit is non-zero whenever the subtraction matters, so no underflow
    assign fire_s       = (state_r == ST_IDLE) && enable && any_trig_s &&
                          (trig_limit != CNT_ZERO) &&
                          (trig_len_r == (trig_limit - CNT_ONE));
    // Mode 3 is reserved and behaves as PAUSE
    assign pause_mode_s = (mode != 2'd1);
    assign reset_mode_s = (mode == 2'd1) || (mode == 2'd2);
    // Load value gives max(override_len,1) cycles of pause_override
    assign ovl_load_s   = (override_len == CNT_ZERO) ? CNT_ZERO : (override_len - CNT_ONE);

    // Watchdog FSM: run-length counting, action sequencing and action outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            trig_len_r <= CNT_ZERO;
            cnt_r      <= CNT_ZERO;
            hold_len_r <= CNT_ZERO;
            pause_r    <= 1'b0;
            bsum_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else if (!enable) begin
            state_r    <= ST_IDLE;
            trig_len_r <= CNT_ZERO;
            cnt_r      <= CNT_ZERO;
            pause_r    <= 1'b0;
            bsum_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bsum_r <= 1'b0;
                    if (fire_s) begin
                        trig_len_r <= CNT_ZERO;
                        hold_len_r <= holdoff_len;
                        bsum_r     <= reset_mode_s;
                        if (pause_mode_s) begin
                            state_r <= ST_OVERRIDE;
                            cnt_r   <= ovl_load_s;
                            pause_r <= 1'b1;
                            busy_r  <= 1'b1;
                        end else if (holdoff_len != CNT_ZERO) begin
                            state_r <= ST_HOLDOFF;
                            cnt_r   <= holdoff_len - CNT_ONE;
                            busy_r  <= 1'b1;
                        end else begin
                            // No holdoff: stay armed, counting resumes next edge
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (any_trig_s) begin
                        trig_len_r <= sat_inc_cnt(trig_len_r);
                    end else begin
                        trig_len_r <= CNT_ZERO;
                    end
                end
                ST_OVERRIDE: begin
                    bsum_r     <= 1'b0;
                    trig_len_r <= CNT_ZERO;
                    if (cnt_r == CNT_ZERO) begin
                        pause_r <= 1'b0;
                        if (hold_len_r != CNT_ZERO) begin
                            state_r <= ST_HOLDOFF;
                            cnt_r   <= hold_len_r - CNT_ONE;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_HOLDOFF: begin
                    bsum_r     <= 1'b0;
                    pause_r    <= 1'b0;
                    trig_len_r <= CNT_ZERO;
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    trig_len_r <= CNT_ZERO;
                    cnt_r      <= CNT_ZERO;
                    pause_r    <= 1'b0;
                    bsum_r     <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Sticky diagnostics; a fire coinciding with clear lands on a cleared base
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_r  <= MASK_ZERO;
            count_r <= {EVT_W{1'b0}};
        end else if (fire_s) begin
            mask_r  <= (clear ? MASK_ZERO : mask_r) | tot;
            count_r <= clear ? EVT_ONE : sat_inc_evt(count_r);
        end else if (clear) begin
            mask_r  <= MASK_ZERO;
            count_r <= {EVT_W{1'b0}};
        end else begin
            mask_r  <= mask_r;
            count_r <= count_r;
        end
    end

    assign pause_override = pause_r;
    assign bsum_reset     = bsum_r;
    assign busy           = busy_r;
    assign stuck_mask     = mask_r;
    assign stuck_count    = count_r;

endmodule

// File: tb/tb_trig_watchdog.sv
// -----------------------------------------------------------------------------
// tb_trig_watchdog
// Directed bench for trig_watchdog with hand-computed expectations. Edge 0 of
// each scenario is the first rising edge that samples the new stimulus. The
// event counter is built 2 bits wide so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_trig_watchdog;

    logic        clk;
    logic        rst;
    logic [3:0]  tot;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] trig_limit;
    logic [15:0] override_len;
    logic [15:0] holdoff_len;
    logic        clear;
    logic        pause_override;
    logic        bsum_reset;
    logic        busy;
    logic [3:0]  stuck_mask;
    logic [1:0]  stuck_count;

    int n_checks;
    int n_fail;

    trig_watchdog #(
        .NUM_CH (4),
        .CNT_W  (16),
        .EVT_W  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tot            (tot),
        .enable         (enable),
        .mode           (mode),
        .trig_limit     (trig_limit),
        .override_len   (override_len),
        .holdoff_len    (holdoff_len),
        .clear          (clear),
        .pause_override (pause_override),
        .bsum_reset     (bsum_reset),
        .busy           (busy),
        .stuck_mask     (stuck_mask),
        .stuck_count    (stuck_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return to IDLE with cleared diagnostics
    task automatic quiesce();
        tot    = 4'b0000;
        enable = 1'b0;
        clear  = 1'b1;
        step();
        clear  = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        tot          = 4'b0000;
        enable       = 1'b1;
        mode         = 2'd0;
        trig_limit   = 16'd20;
        override_len = 16'd20;
        holdoff_len  = 16'd0;
        clear        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_pause", 32'(pause_override), 32'd0);
        chk("rst_bsum",  32'(bsum_reset),     32'd0);
        chk("rst_busy",  32'(busy),           32'd0);
        chk("rst_mask",  32'(stuck_mask),     32'd0);
        chk("rst_count", 32'(stuck_count),    32'd0);

        // 1. PAUSE basic: fires at 19 and 59, pause held 20 cycles
        mode = 2'd0; trig_limit = 16'd20; override_len = 16'd20; holdoff_len = 16'd0;
        tot = 4'b0001;
        for (int e = 0; e < 60; e++) begin
            step();
            chk("t1_pause", 32'(pause_override), 32'((e >= 19 && e <= 38) || e == 59));
            chk("t1_bsum",  32'(bsum_reset),     32'd0);
        end
        chk("t1_count", 32'(stuck_count), 32'd2);
        chk("t1_mask",  32'(stuck_mask),  32'h1);
        quiesce();

        // 2. RESET with holdoff 10: pulses at 19, 49, 79
        mode = 2'd1; trig_limit = 16'd20; holdoff_len = 16'd10;
        tot = 4'b0100;
        for (int e = 0; e < 86; e++) begin
            step();
            chk("t2_bsum",  32'(bsum_reset),     32'(e == 19 || e == 49 || e == 79));
            chk("t2_pause", 32'(pause_override), 32'd0);
            chk("t2_busy",  32'(busy),           32'(e >= 19 && ((e - 19) % 30) < 10));
        end
        chk("t2_count", 32'(stuck_count), 32'd3);
        chk("t2_mask",  32'(stuck_mask),  32'h4);
        quiesce();

        // 3. Short pulses never fire; rotating channels count as one trigger
        mode = 2'd0; trig_limit = 16'd20; override_len = 16'd20; holdoff_len = 16'd0;
        for (int r = 0; r < 5; r++) begin
            for (int e = 0; e < 20; e++) begin
                tot = (e < 19) ? 4'b0001 : 4'b0000;
                step();
                chk("t3_short", 32'({pause_override, bsum_reset}), 32'd0);
            end
        end
        chk("t3_count0", 32'(stuck_count), 32'd0);
        for (int e = 0; e < 20; e++) begin
            tot = 4'(4'b0001 << (e % 3));
            step();
            chk("t3_rot_pause", 32'(pause_override), 32'(e == 19));
        end
        chk("t3_rot_mask",  32'(stuck_mask),  32'h2);
        chk("t3_rot_count", 32'(stuck_count), 32'd1);
        quiesce();

        // 4. BOTH: fire at 2, pause 2..6, bsum at 2, holdoff 4 ends at 11
        mode = 2'd2; trig_limit = 16'd3; override_len = 16'd5; holdoff_len = 16'd4;
        tot = 4'b0001;
        for (int e = 0; e < 12; e++) begin
            step();
            chk("t4_pause", 32'(pause_override), 32'(e >= 2 && e <= 6));
            chk("t4_bsum",  32'(bsum_reset),     32'(e == 2));
            chk("t4_busy",  32'(busy),           32'(e >= 2 && e <= 10));
        end
        quiesce();

        // 5a. Drop enable mid-OVERRIDE
        mode = 2'd0; trig_limit = 16'd3; override_len = 16'd10; holdoff_len = 16'd0;
        tot = 4'b0001;
        for (int e = 0; e < 5; e++) begin
            step();
            chk("t5_pre_pause", 32'(pause_override), 32'(e >= 2));
        end
        enable = 1'b0;
        step();
        chk("t5_dis_pause", 32'(pause_override), 32'd0);
        chk("t5_dis_busy",  32'(busy),           32'd0);
        chk("t5_dis_count", 32'(stuck_count),    32'd1);
        enable = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            chk("t5_rearm_pause", 32'(pause_override), 32'(e == 2));
        end

        // 5b. Asynchronous reset mid-action
        rst = 1'b1;
        #2;
        chk("t5_rst_pause", 32'(pause_override), 32'd0);
        chk("t5_rst_busy",  32'(busy),           32'd0);
        chk("t5_rst_count", 32'(stuck_count),    32'd0);
        rst = 1'b0;
        tot = 4'b0000;
        step();

        // 5c. trig_limit = 0 never fires
        trig_limit = 16'd0;
        tot = 4'b1111;
        for (int e = 0; e < 1000; e++) begin
            step();
            chk("t5_lim0", 32'({pause_override, bsum_reset}), 32'd0);
        end
        chk("t5_lim0_count", 32'(stuck_count), 32'd0);
        quiesce();

        // 5d. override_len = 0 gives a single pause cycle, then holdoff
        mode = 2'd0; trig_limit = 16'd1; override_len = 16'd0; holdoff_len = 16'd3;
        for (int e = 0; e < 3; e++) begin
            tot = (e == 0) ? 4'b0001 : 4'b0000;
            step();
            chk("t5_ovl0_pause", 32'(pause_override), 32'(e == 0));
            chk("t5_ovl0_busy",  32'(busy),           32'd1);
        end
        quiesce();

        // 6. Saturation of the 2-bit counter, then clear coincident with fire
        mode = 2'd1; trig_limit = 16'd1; holdoff_len = 16'd0;
        tot = 4'b0001;
        for (int e = 0; e < 5; e++) begin
            step();
            chk("t6_bsum",  32'(bsum_reset),  32'd1);
            chk("t6_count", 32'(stuck_count), 32'((e < 3) ? e + 1 : 3));
        end
        chk("t6_mask", 32'(stuck_mask), 32'h1);
        tot   = 4'b1000;
        clear = 1'b1;
        step();
        chk("t6_clrfire_count", 32'(stuck_count), 32'd1);
        chk("t6_clrfire_mask",  32'(stuck_mask),  32'h8);
        tot   = 4'b0000;
        clear = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t6_clr_count", 32'(stuck_count), 32'd0);
        chk("t6_clr_mask",  32'(stuck_mask),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
